// File: rtl/conv_layer_ifft_pack_pkg.sv
// rtl/conv_layer_ifft_pack_pkg.sv - shared types, sizes and helpers for the inverse-FFT pack path
package conv_layer_ifft_pack_pkg;

   localparam int TILE_N         = 4;
   localparam int TILES_PER_LINE = 4;
   localparam int CACHELINE_W    = 512;
   localparam int ELEM_W         = 64;
   localparam int TILE_BITS      = TILE_N * TILE_N * ELEM_W;
   localparam int MEM_DATA_W     = TILES_PER_LINE * TILE_BITS;

   // Real part sits in the low half so a raw 64-bit memory element casts straight to complex_t.
   typedef struct packed {
      logic signed [31:0] i;
      logic signed [31:0] r;
   } complex_t;

   typedef complex_t [TILE_N-1:0] cvec4_t;
   typedef cvec4_t   [TILE_N-1:0] ctile_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FIN
   } state_t;

   function automatic int elem_offset(input int t, input int r, input int c);
      return ELEM_W * (TILE_N * TILE_N * t + TILE_N * r + c);
   endfunction

   function automatic complex_t c_add(input complex_t a, input complex_t b);
      complex_t y;
      y.r = a.r + b.r;
      y.i = a.i + b.i;
      return y;
   endfunction

   function automatic complex_t c_sub(input complex_t a, input complex_t b);
      complex_t y;
      y.r = a.r - b.r;
      y.i = a.i - b.i;
      return y;
   endfunction

   function automatic complex_t c_mul_j(input complex_t a);
      complex_t y;
      y.r = -a.i;
      y.i = a.r;
      return y;
   endfunction

   function automatic cvec4_t ifft4_stage_a(input cvec4_t x);
      cvec4_t y;
      y[0] = c_add(x[0], x[2]);
      y[1] = c_sub(x[0], x[2]);
      y[2] = c_add(x[1], x[3]);
      y[3] = c_sub(x[1], x[3]);
      return y;
   endfunction

   // Inverse twiddle is +j, so odd outputs combine with j*a3 instead of -j*a3.
   function automatic cvec4_t ifft4_stage_b(input cvec4_t a);
      cvec4_t y;
      y[0] = c_add(a[0], a[2]);
      y[1] = c_add(a[1], c_mul_j(a[3]));
      y[2] = c_sub(a[0], a[2]);
      y[3] = c_sub(a[1], c_mul_j(a[3]));
      return y;
   endfunction

endpackage

// File: rtl/conv_layer_ifft_pack_ifft4_2d.sv
// rtl/conv_layer_ifft_pack_ifft4_2d.sv - 4x4 complex 2-D inverse FFT, fixed 4-cycle latency
module conv_layer_ifft_pack_ifft4_2d
   import conv_layer_ifft_pack_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [TILE_BITS-1:0] in_tile,
   output logic                 out_valid,
   output logic [TILE_BITS-1:0] out_tile
);

   ctile_t     in_t;
   ctile_t     s1_d, s1_q, s2_d, s2_q, s3_d, s3_q, s4_d, s4_q;
   logic [3:0] vld_d, vld_q;

   assign in_t = in_tile;

   // Rows in stages 1-2, columns in stages 3-4.
   always_comb begin
      cvec4_t col_in;
      cvec4_t col_out;
      col_in  = '0;
      col_out = '0;
      s1_d    = '0;
      s2_d    = '0;
      s3_d    = '0;
      s4_d    = '0;
      vld_d   = {vld_q[2:0], in_valid};
      for (int r = 0; r < TILE_N; r++) begin
         s1_d[r] = ifft4_stage_a(in_t[r]);
         s2_d[r] = ifft4_stage_b(s1_q[r]);
      end
      for (int c = 0; c < TILE_N; c++) begin
         for (int r = 0; r < TILE_N; r++) col_in[r] = s2_q[r][c];
         col_out = ifft4_stage_a(col_in);
         for (int r = 0; r < TILE_N; r++) s3_d[r][c] = col_out[r];
         for (int r = 0; r < TILE_N; r++) col_in[r] = s3_q[r][c];
         col_out = ifft4_stage_b(col_in);
         for (int r = 0; r < TILE_N; r++) s4_d[r][c] = col_out[r];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_d;
   end

   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
   end

   assign out_valid = vld_q[3];
   assign out_tile  = s4_q;

endmodule

// File: rtl/conv_layer_ifft_pack.sv
// rtl/conv_layer_ifft_pack.sv - tile-set reader, 4x inverse FFT, 2x2 real repack, credited output FIFO
// IFFT_SCALE_EN: when defined, packed reals are (x+8)>>>4; otherwise raw sums.
module conv_layer_ifft_pack
   import conv_layer_ifft_pack_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ADDR_W:0]        num_sets,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_rd_addr,
   input  logic [MEM_DATA_W-1:0]  mem_rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CACHELINE_W-1:0] out_cacheline
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   state_t                  state_d, state_q;
   logic [ADDR_W-1:0]       addr_d, addr_q;
   logic [ADDR_W:0]         remaining_d, remaining_q;
   logic [CNT_W-1:0]        in_flight_d, in_flight_q;
   logic [CNT_W-1:0]        fifo_count_d, fifo_count_q;
   logic [PTR_W-1:0]        wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic                    rd_valid_d, rd_valid_q;
   logic [CACHELINE_W-1:0]  fifo_mem_q [FIFO_DEPTH];

   logic [TILES_PER_LINE-1:0]                ifft_valid;
   logic [TILES_PER_LINE-1:0][TILE_BITS-1:0] ifft_out;
   logic [CACHELINE_W-1:0]                   packed_line;
   logic                                     credit_ok, issue, push, pop;
   logic                                     unused_ifft;

   for (genvar t = 0; t < TILES_PER_LINE; t++) begin : g_tile
      conv_layer_ifft_pack_ifft4_2d u_ifft4_2d (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (rd_valid_q),
         .in_tile   (mem_rd_data[elem_offset(t, 0, 0) +: TILE_BITS]),
         .out_valid (ifft_valid[t]),
         .out_tile  (ifft_out[t])
      );
   end

   // Reads not yet popped never exceed the FIFO size, so the non-stalling pipeline always has a slot.
   assign credit_ok = ({1'b0, in_flight_q} + {1'b0, fifo_count_q}) < DEPTH_C;
   assign issue     = (state_q == ST_RUN) && credit_ok;
   assign push      = &ifft_valid;
   assign pop       = out_valid && out_ready;

   always_comb begin
      ctile_t             tile;
      logic signed [31:0] re;
      tile        = '0;
      re          = '0;
      packed_line = '0;
      for (int t = 0; t < TILES_PER_LINE; t++) begin
         tile = ifft_out[t];
         for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
               re = tile[r][c].r;
`ifdef IFFT_SCALE_EN
               re = (re + 32'sd8) >>> 4;
`endif
               packed_line[32*(4*t + 2*r + c) +: 32] = re;
            end
         end
      end
   end

   assign unused_ifft = ^ifft_out;

   always_comb begin
      rd_valid_d   = issue;
      in_flight_d  = in_flight_q;
      fifo_count_d = fifo_count_q;
      wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      if (issue && !push)      in_flight_d = in_flight_q + CNT_W'(1);
      else if (!issue && push) in_flight_d = in_flight_q - CNT_W'(1);
      if (push && !pop)        fifo_count_d = fifo_count_q + CNT_W'(1);
      else if (!push && pop)   fifo_count_d = fifo_count_q - CNT_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               remaining_d = num_sets;
               state_d     = (num_sets == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - (ADDR_W + 1)'(1);
               if (remaining_q == (ADDR_W + 1)'(1)) state_d = ST_DRAIN;
            end
         end
         // Using next-cycle counts lets done follow the final handshake by exactly one cycle.
         ST_DRAIN: begin
            if (in_flight_d == '0 && fifo_count_d == '0) state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         in_flight_q  <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         in_flight_q  <= in_flight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= packed_line;
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FIN);
   assign mem_rd_en     = issue;
   assign mem_rd_addr   = addr_q;
   assign out_valid     = (fifo_count_q != '0);
   assign out_cacheline = out_valid ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_conv_layer_ifft_pack.sv
// tb/tb_conv_layer_ifft_pack.sv - randomized bench with a direct inverse-DFT reference model
module tb_conv_layer_ifft_pack;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [9:0]    base_addr;
   logic [10:0]   num_sets;
   logic          busy, done, mem_rd_en, out_valid, out_ready;
   logic [9:0]    mem_rd_addr;
   logic [4095:0] mem_rd_data;
   logic [511:0]  out_cacheline;

   always #5 clk = ~clk;

   conv_layer_ifft_pack #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .num_sets      (num_sets),
      .busy          (busy),
      .done          (done),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_cacheline (out_cacheline)
   );

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   logic [4095:0] mem [1024];

   logic [511:0]  exp_q[$];
   logic [9:0]    addr_log[$];
   logic [9:0]    exp_addr;
   int            issued, accepted, max_out, busy_cnt, first_valid_cyc, last_hs_cyc;
   logic [511:0]  first_line, held_line;
   bit            hold_pending = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      else           mem_rd_data <= {128{32'hdeadbeef}};
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int scale(input int x);
`ifdef IFFT_SCALE_EN
      return (x + 8) >>> 4;
`else
      return x;
`endif
   endfunction

   // Direct inverse 2-D DFT: y(r,c) = sum x(m,n) * j^(m*r + n*c), real part only.
   function automatic logic [511:0] ref_line(input logic [4095:0] d);
      logic [511:0] line;
      int acc, xr, xi, base;
      line = '0;
      for (int t = 0; t < 4; t++)
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
               acc = 0;
               for (int m = 0; m < 4; m++)
                  for (int n = 0; n < 4; n++) begin
                     base = 64 * (16*t + 4*m + n);
                     xr = d[base +: 32];
                     xi = d[base + 32 +: 32];
                     case ((m*r + n*c) % 4)
                        0: acc = acc + xr;
                        1: acc = acc - xi;
                        2: acc = acc - xr;
                        default: acc = acc + xi;
                     endcase
                  end
               line[32*(4*t + 2*r + c) +: 32] = scale(acc);
            end
      return line;
   endfunction

   function automatic logic [4095:0] rand_set(input bit full);
      logic [4095:0] d;
      for (int w = 0; w < 128; w++)
         d[32*w +: 32] = full ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      return d;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         hold_pending = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (hold_pending) begin
            check("hold_valid", 512'(out_valid), 512'(1));
            check("hold_line", out_cacheline, held_line);
         end
         hold_pending = out_valid && !out_ready;
         held_line    = out_cacheline;
         if (mem_rd_en) begin
            check("rd_addr", 512'(mem_rd_addr), 512'(exp_addr));
            addr_log.push_back(mem_rd_addr);
            exp_q.push_back(ref_line(mem[mem_rd_addr]));
            exp_addr = exp_addr + 10'd1;
            issued++;
            if (issued - accepted > max_out) max_out = issued - accepted;
            check("credit", 512'(issued - accepted <= DEPTH), 512'(1));
         end
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 512'(exp_q.size()), 512'(1));
            else                   check("beat_data", out_cacheline, exp_q.pop_front());
            if (accepted == 0) first_line = out_cacheline;
            accepted++;
            last_hs_cyc = cyc;
         end
      end
   end

   task automatic clear_mon(input logic [9:0] base);
      exp_q.delete();
      addr_log.delete();
      exp_addr        = base;
      issued          = 0;
      accepted        = 0;
      max_out         = 0;
      busy_cnt        = 0;
      first_valid_cyc = -1;
      last_hs_cyc     = -1;
      first_line      = '0;
   endtask

   // mode 0: ready always high, 1: ready low for cycles 3..30 after start, 2: random ready.
   task automatic run_job(input logic [9:0] base, input int n, input int mode, input bit fill,
                          input bit poke, output int start_cyc);
      int  rel, done_cyc;
      bit  seen;
      logic [9:0] a;
      if (fill)
         for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            mem[a] = rand_set(1'($urandom_range(0, 1)));
         end
      clear_mon(base);
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; num_sets = 11'(n); out_ready = 1'b1;
      start_cyc = cyc;
      seen = 1'b0; done_cyc = 0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(posedge clk); #1;
         rel   = cyc - start_cyc;
         start = poke && rel == 3;
         if (poke && rel == 3) begin base_addr = 10'd500; num_sets = 11'd3; end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !(rel >= 3 && rel <= 30);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (done) begin seen = 1'b1; done_cyc = cyc; end
      end
      check("done_seen", 512'(seen), 512'(1));
      @(posedge clk); #1;
      out_ready = 1'b1;
      check("done_pulse", 512'({done, busy}), 512'(0));
      check("beats", 512'(accepted), 512'(n));
      check("leftover", 512'(exp_q.size()), 512'(0));
      if (n > 0) begin
         check("done_lat", 512'(done_cyc - last_hs_cyc), 512'(1));
      end else begin
         check("zero_busy", 512'(busy_cnt), 512'(1));
         check("zero_rd", 512'(issued), 512'(0));
      end
   endtask

   initial begin
      int           st;
      logic [511:0] line;
      logic [4095:0] d;
      logic [9:0]   wrap_exp [4];

      reset = 1'b1; start = 1'b0; base_addr = '0; num_sets = '0; out_ready = 1'b1;
      clear_mon(10'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 512'({busy, done, mem_rd_en, mem_rd_addr, out_valid}), 512'(0));
      check("reset_line", out_cacheline, 512'(0));
      reset = 1'b0;

      d = '0;
      for (int t = 0; t < 4; t++) d[1024*t +: 32] = 32'(16 + t);
      mem[100] = d;
      run_job(10'd100, 1, 0, 1'b0, 1'b0, st);
      line = '0;
      for (int t = 0; t < 4; t++)
         for (int w = 0; w < 4; w++)
`ifdef IFFT_SCALE_EN
            line[32*(4*t + w) +: 32] = 32'd1;
`else
            line[32*(4*t + w) +: 32] = 32'(16 + t);
`endif
      check("imp_latency", 512'(first_valid_cyc - st), 512'(7));
      check("imp_line", first_line, line);

      d = '0;
      for (int t = 0; t < 4; t++) d[1024*t +: 32] = 32'd32;
      mem[50] = d;
      run_job(10'd50, 1, 0, 1'b0, 1'b0, st);
`ifdef IFFT_SCALE_EN
      line = {16{32'd2}};
`else
      line = {16{32'd32}};
`endif
      check("dc_line", first_line, line);

      run_job(10'd10, 6, 0, 1'b1, 1'b0, st);

      run_job(10'd200, 20, 1, 1'b1, 1'b0, st);
      check("bp_max_outstanding", 512'(max_out), 512'(DEPTH));

      run_job(10'd700, 12, 2, 1'b1, 1'b1, st);

      run_job(10'd1022, 4, 0, 1'b1, 1'b0, st);
      wrap_exp[0] = 10'd1022; wrap_exp[1] = 10'd1023; wrap_exp[2] = 10'd0; wrap_exp[3] = 10'd1;
      check("wrap_count", 512'(addr_log.size()), 512'(4));
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         check("wrap_addr", 512'(addr_log[i]), 512'(wrap_exp[i]));

      run_job(10'd5, 0, 0, 1'b0, 1'b0, st);

      for (int i = 0; i < 30; i++) mem[10'(300 + i)] = rand_set(1'b1);
      clear_mon(10'd300);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'd300; num_sets = 11'd30; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_busy", 512'(busy), 512'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_ctrl", 512'({busy, done, mem_rd_en, mem_rd_addr, out_valid}), 512'(0));
      check("rst_line", out_cacheline, 512'(0));
      clear_mon(10'd0);
      reset = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_quiet", 512'({out_valid, mem_rd_en, busy}), 512'(0));
      run_job(10'd300, 5, 2, 1'b1, 1'b0, st);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv_layer_ifft_pack.md
# conv_layer_ifft_pack

Return path of the FFT convolution layer: reads frequency-domain tile sets (4 tiles of 4×4 complex values) from the image memory blocks. Runs a 2-D inverse FFT on each tile set. Packs the top-left 2×2 real results of the 4 tiles into one 512-bit cacheline, the exact inverse of the forward tile packing. Output is a valid/ready stream with backpressure, ahead of the host write-back path.

## Interface
Parameters:
- ADDR_W, 10, memory tile-set address width
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥ 8)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first tile-set address, latched on start
- num_sets  in  ADDR_W+1  number of tile sets to process, latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last cacheline is accepted
- mem_rd_en  out  1  read strobe to the 4 image memory blocks
- mem_rd_addr  out  ADDR_W  tile-set address
- mem_rd_data  in  4096  read data, valid exactly 1 cycle after mem_rd_en. Element (t,r,c) is at 64·(16t+4r+c); real part in [31:0], imag part in [63:32], both 32-bit signed.
- out_valid  out  1  cacheline available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_cacheline  out  512  packed result

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE→RUN on start. If num_sets==0, go IDLE→FIN instead.
  - RUN→DRAIN on the cycle the last read is issued.
  - DRAIN→FIN when in-flight==0, the FIFO is empty, and the last beat has been accepted.
  - FIN→IDLE unconditionally. done=1 in FIN only.
- start is ignored outside IDLE.
- Reads are issued in RUN only when in_flight + fifo_count < FIFO_DEPTH (credit check). The address increments by 1 per issued read and wraps modulo 2^ADDR_W.
- in_flight counts reads issued but not yet written to the FIFO. It increments on issue and decrements on FIFO write; both can happen in the same cycle.
- The inverse FFT pipeline cannot stall. The credit check guarantees the FIFO never overflows.
- Packing: cacheline word k = 4t + 2r + c (t∈0..3, r,c∈0..1) occupies bits [32k+31:32k] and holds the real part of inverse-FFT output (t,r,c). Imaginary parts and rows/cols 2..3 are discarded.
- Arithmetic: 32-bit two's complement throughout, wrap on overflow, no saturation. Butterfly twiddles are ±1 and ±j only, so the datapath is adders and swaps with no multipliers.
- FIFO: simultaneous push and pop when full or empty is legal. A pop is a same-cycle accept.
- Reset in any state returns to IDLE. Reset clears counters, the FIFO, and pipeline valid bits, and discards in-flight data.

## Timing
- All outputs reset to 0.
- start accepted at edge N → first mem_rd_en in cycle N+1.
- mem_rd_en in cycle C → data in cycle C+1 → registered into ifft4_2d at the end of C+1 → 4-stage pipeline → FIFO write at the end of C+5 → out_valid in C+6 (empty FIFO).
- Throughput is one cacheline per cycle while out_ready=1.
- out_cacheline is held stable while out_valid=1 and out_ready=0.
- done is asserted the cycle after the final handshake.

## Configuration
- IFFT_SCALE_EN defined: each output real value is divided by 16 using an arithmetic shift right by 4 with round-half-up ((x+8)>>>4). This makes the inverse an exact inverse of the unscaled forward 2-D FFT.
- IFFT_SCALE_EN undefined: raw unscaled sums are output (16× the true value), and the consumer scales.

## Structure
- The shared package holds:
  - complex_t (32-bit signed r, i)
  - TILE_N=4, TILES_PER_LINE=4, CACHELINE_W=512
  - the mem_rd_data unpack offsets
- Sub-module ifft4_2d:
  - 4×4 complex in/out with a valid bit, fixed 4-cycle latency
  - row inverse FFT4 in stages 1–2, column inverse FFT4 in stages 3–4
  - one instance per tile, 4 instances total
- The FIFO stays local: register array with read/write pointers and a count.

## Test plan
- Single set, impulse: tile t element (0,0) = 16+t, all others 0, out_ready=1. Expect all four 2×2 words of tile t = 16+t unscaled (1+t/16 truncated: 1 scaled). out_valid 7 cycles after start; done 1 cycle after the handshake.
- DC only: every tile (0,0)=32 → scaled line of sixteen 2s; unscaled sixteen 32s.
- Backpressure: num_sets=20, out_ready low for cycles 3–30. mem_rd_en stops after 8 outstanding; no data lost; 20 beats in address order.
- Wrap: ADDR_W=10, base_addr=1022, num_sets=4 → addresses 1022, 1023, 0, 1.
- num_sets=0 → busy for 1 cycle, done pulse, no mem_rd_en. start while busy → ignored.
- Reset asserted mid-RUN with 5 in flight → next cycle all outputs 0. A new start produces only fresh results.
